// File: rtl/misr_pkg.sv
// Shared types, defaults and the MISR step function for the
// response compactor and its reference model.
package misr_pkg;

  localparam int MISR_W = 29;

  localparam logic [MISR_W-1:0] POLY_29 = 29'h0000005;
  localparam logic [MISR_W-1:0] SEED_29 = 29'h0000000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic [MISR_W-1:0] misr_next(
    input logic [MISR_W-1:0] sig,
    input logic [MISR_W-1:0] data,
    input logic [MISR_W-1:0] poly
  );
    return {sig[MISR_W-2:0], 1'b0}
         ^ (sig[MISR_W-1] ? poly : '0)
         ^ data;
  endfunction

endpackage

// File: rtl/misr_core.sv
// Signature register: seed load, one GF(2) step per accepted beat,
// and a look-ahead of the stepped value for the pass compare.
module misr_core
  import misr_pkg::*;
#(
  parameter int              WIDTH = MISR_W,
  parameter logic [WIDTH-1:0] POLY = POLY_29,
  parameter logic [WIDTH-1:0] SEED = SEED_29
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] sig,
  output logic [WIDTH-1:0] sig_step
);

  logic [WIDTH-1:0] sig_q;
  logic [WIDTH-1:0] sig_d;

  always_comb begin
    sig_step = misr_next(sig_q, data, POLY);
    sig_d    = sig_q;
    if (load) begin
      sig_d = SEED;
    end else if (step) begin
      sig_d = sig_step;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q <= SEED;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/resp_misr_compactor.sv
// Response compactor: run FSM, beat counter and golden-signature
// compare around a MISR core.
module resp_misr_compactor
  import misr_pkg::*;
#(
  parameter int               WIDTH = MISR_W,
  parameter logic [WIDTH-1:0] POLY  = POLY_29,
  parameter logic [WIDTH-1:0] SEED  = SEED_29,
  parameter int               CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_patterns,
  input  logic [WIDTH-1:0] expected_sig,
  input  logic             resp_valid,
  input  logic [WIDTH-1:0] resp_data,
  output logic             resp_ready,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] signature,
  output logic [CNT_W-1:0] beat_count
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic             pass_q, pass_d;

  logic             load;
  logic             beat;
  logic [WIDTH-1:0] sig_step;

  assign beat = resp_valid && (state_q == RUN);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    exp_d   = exp_q;
    pass_d  = pass_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          load   = 1'b1;
          cnt_d  = '0;
          num_d  = num_patterns;
          exp_d  = expected_sig;
          pass_d = 1'b0;
          if (num_patterns == '0) begin
            state_d = DONE;
            pass_d  = (SEED == expected_sig);
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (beat) begin
          cnt_d = cnt_q + 1'b1;
          // Last beat: compare the value the MISR is about to take.
          if (cnt_q == num_q - 1'b1) begin
            state_d = DONE;
            pass_d  = (sig_step == exp_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      num_q   <= '0;
      exp_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      exp_q   <= exp_d;
      pass_q  <= pass_d;
    end
  end

  misr_core #(
    .WIDTH(WIDTH),
    .POLY (POLY),
    .SEED (SEED)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .step    (beat),
    .data    (resp_data),
    .sig     (signature),
    .sig_step(sig_step)
  );

  assign resp_ready = (state_q == RUN);
  assign busy       = (state_q == RUN);
  assign done       = (state_q == DONE);
  assign pass       = pass_q;
  assign beat_count = cnt_q;

endmodule

// File: tb/tb_resp_misr_compactor.sv
// Directed bench for resp_misr_compactor with a misr_next
// reference model for the longer runs.
module tb_resp_misr_compactor;
  import misr_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] num_patterns;
  logic [28:0] expected_sig;
  logic        resp_valid;
  logic [28:0] resp_data;
  logic        resp_ready;
  logic        busy;
  logic        done;
  logic        pass;
  logic [28:0] signature;
  logic [15:0] beat_count;

  int total = 0;
  int fails = 0;

  logic [28:0] model;
  logic [28:0] vec [0:99];

  always #5 clk = ~clk;

  resp_misr_compactor dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .num_patterns(num_patterns),
    .expected_sig(expected_sig),
    .resp_valid  (resp_valid),
    .resp_data   (resp_data),
    .resp_ready  (resp_ready),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .signature   (signature),
    .beat_count  (beat_count)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic beat_in(input logic [28:0] d);
    resp_valid = 1'b1;
    resp_data  = d;
    cyc();
    resp_valid = 1'b0;
  endtask

  task automatic go(input logic [15:0] n, input logic [28:0] e);
    start        = 1'b1;
    num_patterns = n;
    expected_sig = e;
    cyc();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; num_patterns = '0;
    expected_sig = '0; resp_valid = 1'b0; resp_data = '0;
    cyc(); cyc();
    rst = 1'b0;
    cyc();
    chk("rst_ready", 32'(resp_ready), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_done",  32'(done), 32'd0);
    chk("rst_pass",  32'(pass), 32'd0);
    chk("rst_sig",   32'(signature), 32'h0);
    chk("rst_cnt",   32'(beat_count), 32'd0);

    // Single-beat shift
    go(16'd1, 29'h0000001);
    chk("s1_busy",  32'(busy), 32'd1);
    chk("s1_ready", 32'(resp_ready), 32'd1);
    beat_in(29'h0000001);
    chk("s1_done", 32'(done), 32'd1);
    chk("s1_sig",  32'(signature), 32'h1);
    chk("s1_cnt",  32'(beat_count), 32'd1);
    chk("s1_pass", 32'(pass), 32'd1);
    chk("s1_busy0", 32'(busy), 32'd0);

    // Feedback through bit 28
    go(16'd2, 29'h0000005);
    beat_in(29'h10000000);
    chk("fb_mid",  32'(signature), 32'h10000000);
    chk("fb_nd",   32'(done), 32'd0);
    beat_in(29'h0000000);
    chk("fb_sig",  32'(signature), 32'h5);
    chk("fb_pass", 32'(pass), 32'd1);

    // Stalls with garbage data while not valid
    go(16'd2, 29'h0000000);
    beat_in(29'h0000001);
    resp_data = 29'h1ABCDEF;
    cyc(); cyc(); cyc();
    chk("st_sig",  32'(signature), 32'h1);
    chk("st_cnt",  32'(beat_count), 32'd1);
    chk("st_nd",   32'(done), 32'd0);
    beat_in(29'h0000000);
    chk("st_sig2", 32'(signature), 32'h2);
    chk("st_done", 32'(done), 32'd1);
    chk("st_pass", 32'(pass), 32'd0);

    // Zero-length run, start+valid together in DONE
    resp_valid = 1'b1;
    resp_data  = 29'h0001234;
    go(16'd0, 29'h0000000);
    resp_valid = 1'b0;
    chk("z_done",  32'(done), 32'd1);
    chk("z_ready", 32'(resp_ready), 32'd0);
    chk("z_sig",   32'(signature), 32'h0);
    chk("z_cnt",   32'(beat_count), 32'd0);
    chk("z_pass",  32'(pass), 32'd1);

    // Reset mid-run
    for (int i = 0; i < 100; i++) vec[i] = 29'($urandom);
    go(16'd10, 29'h0000000);
    model = '0;
    for (int i = 0; i < 4; i++) begin
      beat_in(vec[i]);
      model = misr_next(model, vec[i], POLY_29);
    end
    chk("rm_cnt", 32'(beat_count), 32'd4);
    chk("rm_sig", 32'(signature), 32'(model));
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rm_busy", 32'(busy), 32'd0);
    chk("rm_sig0", 32'(signature), 32'h0);
    chk("rm_cnt0", 32'(beat_count), 32'd0);
    chk("rm_done", 32'(done), 32'd0);

    model = '0;
    for (int i = 0; i < 10; i++) model = misr_next(model, vec[i], POLY_29);
    go(16'd10, model);
    for (int i = 0; i < 10; i++) beat_in(vec[i]);
    chk("fr_sig",  32'(signature), 32'(model));
    chk("fr_cnt",  32'(beat_count), 32'd10);
    chk("fr_pass", 32'(pass), 32'd1);

    // Mismatch, start ignored mid-run, hold and restart
    model = '0;
    for (int i = 0; i < 100; i++) model = misr_next(model, vec[i], POLY_29);
    go(16'd100, ~model);
    for (int i = 0; i < 100; i++) begin
      if (i == 50) begin
        start        = 1'b1;
        num_patterns = 16'd1;
        expected_sig = model;
      end
      beat_in(vec[i]);
      start = 1'b0;
      if (i == 50) chk("mm_ign", 32'(beat_count), 32'd51);
    end
    chk("mm_done", 32'(done), 32'd1);
    chk("mm_pass", 32'(pass), 32'd0);
    chk("mm_sig",  32'(signature), 32'(model));
    chk("mm_cnt",  32'(beat_count), 32'd100);
    cyc(); cyc(); cyc();
    chk("mm_hold", 32'(done), 32'd1);
    go(16'd1, 29'h0000003);
    chk("rs_done", 32'(done), 32'd0);
    chk("rs_busy", 32'(busy), 32'd1);
    chk("rs_sig",  32'(signature), 32'h0);
    chk("rs_cnt",  32'(beat_count), 32'd0);
    beat_in(29'h0000003);
    chk("rs_pass", 32'(pass), 32'd1);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
